// File: rtl/adc_serial_deser_if.sv
// ---------------------------------------------------------------------------
// adc_serial_deser_if : frame/bit inputs and parallel word outputs of the deserializer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface adc_serial_deser_if #(
  parameter int NCH    = 3,
  parameter int WORD_W = 16
);
  logic                    valid_i;
  logic [NCH-1:0]          bit_i;
  logic                    err_clr;
  logic                    valid_o;
  logic [NCH*WORD_W-1:0]   data_o;
  logic [15:0]             word_cnt_o;
  logic                    frame_err_o;
  logic                    busy_o;

  modport master (
    output valid_i, bit_i, err_clr,
    input  valid_o, data_o, word_cnt_o, frame_err_o, busy_o
  );

  modport slave (
    input  valid_i, bit_i, err_clr,
    output valid_o, data_o, word_cnt_o, frame_err_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/adc_serial_deser.sv
// ---------------------------------------------------------------------------
// adc_serial_deser : lockstep multi-channel serial ADC word deserializer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_serial_deser #(
  parameter int NCH       = 3,
  parameter int WORD_W    = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  adc_serial_deser_if.slave bus
);

  localparam int              CNT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
  logic [NCH-1:0][WORD_W-1:0]    sr_q, sr_d;
  logic [NCH-1:0][WORD_W-1:0]    data_q, data_d;
  logic                          valid_q, valid_d;
  logic [15:0]                   word_cnt_q, word_cnt_d;
  logic                          frame_err_q, frame_err_d;
  logic                          busy_q, busy_d;
  logic [NCH-1:0][WORD_W-1:0]    w_shifted;
  logic                          w_last_bit;

  assign w_last_bit = (bit_cnt_q == C_LAST_BIT);

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      if (MSB_FIRST != 0) begin : g_msb
        assign w_shifted[c] = (sr_q[c] << 1) | WORD_W'(bus.bit_i[c]);
      end else begin : g_lsb
        assign w_shifted[c] = (sr_q[c] >> 1) | (WORD_W'(bus.bit_i[c]) << (WORD_W - 1));
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    word_cnt_d  = word_cnt_q;
    frame_err_d = frame_err_q;

    if (bus.err_clr) begin
      frame_err_d = 1'b0;
    end

    if (bus.valid_i) begin
      if (w_last_bit) begin
        data_d     = w_shifted;
        valid_d    = 1'b1;
        word_cnt_d = word_cnt_q + 16'd1;
        sr_d       = '0;
        bit_cnt_d  = '0;
      end else begin
        sr_d      = w_shifted;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.valid_i && !w_last_bit) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.valid_i) begin
          // Gate dropped mid-word: drop the partial word; set beats err_clr.
          state_d     = IDLE;
          sr_d        = '0;
          bit_cnt_d   = '0;
          frame_err_d = 1'b1;
        end else if (w_last_bit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      word_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      word_cnt_q  <= word_cnt_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.word_cnt_o  = word_cnt_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_deser.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_deser : MSB- and LSB-first instances checked against a frame-level model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_serial_deser;

  localparam int NCH    = 3;
  localparam int WORD_W = 16;
  localparam int DW     = NCH * WORD_W;
  localparam int OBS_W  = 2 * (DW + 19);

  logic clk;
  logic rst;

  adc_serial_deser_if #(.NCH(NCH), .WORD_W(WORD_W)) ifm ();
  adc_serial_deser_if #(.NCH(NCH), .WORD_W(WORD_W)) ifl ();
  adc_serial_deser_if #(.NCH(1),   .WORD_W(1))      ifw ();

  adc_serial_deser #(.NCH(NCH), .WORD_W(WORD_W), .MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(ifm));
  adc_serial_deser #(.NCH(NCH), .WORD_W(WORD_W), .MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(ifl));
  adc_serial_deser #(.NCH(1),   .WORD_W(1),      .MSB_FIRST(1)) dut_w (.clk(clk), .rst(rst), .bus(ifw));

  assign ifl.valid_i = ifm.valid_i;
  assign ifl.bit_i   = ifm.bit_i;
  assign ifl.err_clr = ifm.err_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the current frame in arrival order, words built on completion.
  int             nbits;
  logic [NCH-1:0] hist [WORD_W];
  logic           m_valid, m_err, m_busy;
  logic [DW-1:0]  m_dm, m_dl;
  logic [15:0]    m_cnt;

  logic [OBS_W-1:0] obs, exp_obs;
  assign obs = {ifm.valid_o, ifm.data_o, ifm.word_cnt_o, ifm.frame_err_o, ifm.busy_o,
                ifl.valid_o, ifl.data_o, ifl.word_cnt_o, ifl.frame_err_o, ifl.busy_o};
  assign exp_obs = {m_valid, m_dm, m_cnt, m_err, m_busy, m_valid, m_dl, m_cnt, m_err, m_busy};

  task automatic cycle(input logic r, input logic v, input logic [NCH-1:0] b, input logic clr);
    rst = r; ifm.valid_i = v; ifm.bit_i = b; ifm.err_clr = clr;
    @(posedge clk);
    if (r) begin
      nbits = 0; m_valid = 0; m_err = 0; m_busy = 0; m_dm = '0; m_dl = '0; m_cnt = '0;
    end else begin
      m_valid = 0;
      if (clr) m_err = 0;
      if (v) begin
        hist[nbits] = b;
        nbits++;
        if (nbits == WORD_W) begin
          for (int c = 0; c < NCH; c++)
            for (int i = 0; i < WORD_W; i++) begin
              m_dm[c*WORD_W + WORD_W-1-i] = hist[i][c];
              m_dl[c*WORD_W + i]          = hist[i][c];
            end
          m_valid = 1;
          m_cnt   = m_cnt + 16'd1;
          nbits   = 0;
        end
      end else if (nbits > 0) begin
        m_err = 1;
        nbits = 0;
      end
      m_busy = (nbits > 0);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, NCH'($urandom), 1'b1);
      checks++;
      if (obs !== '0) begin
        errors++; $display("FAIL reset cyc%0d: got %h required 0", i, obs);
      end
    end
  endtask

  task automatic test_single_word();
    logic [15:0] w [NCH];
    logic [NCH-1:0] b;
    w[0] = 16'hA5C3; w[1] = 16'h1234; w[2] = 16'hFFFF;
    for (int i = 0; i < WORD_W; i++) begin
      for (int c = 0; c < NCH; c++) b[c] = w[c][WORD_W-1-i];
      cycle(1'b0, 1'b1, b, 1'b0);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL single_word cyc%0d: got %h required %h", i, obs, exp_obs);
      end
    end
    checks++;
    if ({ifm.valid_o, ifm.data_o, ifm.word_cnt_o} !== {1'b1, 48'hFFFF_1234_A5C3, 16'd1}) begin
      errors++; $display("FAIL single_word_strobe: got %b %h %h required 1 ffff1234a5c3 0001",
                         ifm.valid_o, ifm.data_o, ifm.word_cnt_o);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp_obs) begin
      errors++; $display("FAIL single_word_hold: got %h required %h", obs, exp_obs);
    end
  endtask

  task automatic test_back_to_back();
    int strobes[$];
    logic [15:0] cnt0;
    cnt0 = m_cnt;
    for (int i = 0; i < 3*WORD_W; i++) begin
      cycle(1'b0, 1'b1, NCH'($urandom), 1'b0);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL back_to_back cyc%0d: got %h required %h", i, obs, exp_obs);
      end
      if (ifm.valid_o === 1'b1) strobes.push_back(i);
    end
    checks++;
    if (strobes.size() != 3 || strobes[0] != 15 || strobes[1] != 31 || strobes[2] != 47) begin
      errors++; $display("FAIL back_to_back_strobes: got %0d strobes first at %0d required 3 at 15/31/47",
                         strobes.size(), (strobes.size() > 0) ? strobes[0] : -1);
    end
    checks++;
    if (ifm.word_cnt_o !== cnt0 + 16'd3) begin
      errors++; $display("FAIL back_to_back_count: got %h required %h", ifm.word_cnt_o, cnt0 + 16'd3);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_short_frame();
    logic seen_valid;
    seen_valid = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, NCH'($urandom), 1'b0);
      if (ifm.valid_o === 1'b1) seen_valid = 1;
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({seen_valid, ifm.valid_o, ifm.frame_err_o, ifm.busy_o} !== 4'b0010 || obs !== exp_obs) begin
      errors++; $display("FAIL short_frame: got seen=%b v=%b err=%b busy=%b (%h) required 0010 (%h)",
                         seen_valid, ifm.valid_o, ifm.frame_err_o, ifm.busy_o, obs, exp_obs);
    end
    for (int i = 0; i < WORD_W; i++) begin
      cycle(1'b0, 1'b1, NCH'($urandom), 1'b0);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL short_frame_next cyc%0d: got %h required %h", i, obs, exp_obs);
      end
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (ifm.frame_err_o !== 1'b0 || ifl.frame_err_o !== 1'b0) begin
      errors++; $display("FAIL err_clr: got %b/%b required 0", ifm.frame_err_o, ifl.frame_err_o);
    end
  endtask

  task automatic test_lsb_first();
    logic [NCH-1:0] b;
    for (int i = 0; i < WORD_W; i++) begin
      b = NCH'($urandom);
      b[0] = (i == 0);
      cycle(1'b0, 1'b1, b, 1'b0);
    end
    checks++;
    if (ifl.data_o[15:0] !== 16'h0001 || ifm.data_o[15:0] !== 16'h8000 || obs !== exp_obs) begin
      errors++; $display("FAIL lsb_first: got lsb=%h msb=%h required 0001/8000 (%h vs %h)",
                         ifl.data_o[15:0], ifm.data_o[15:0], obs, exp_obs);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, NCH'($urandom), 1'b0);
    cycle(1'b1, 1'b1, NCH'($urandom), 1'b0);
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL rst_mid: got %h required 0", obs);
    end
    for (int i = 0; i < WORD_W; i++) begin
      cycle(1'b0, 1'b1, NCH'($urandom), 1'b0);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL rst_mid_next cyc%0d: got %h required %h", i, obs, exp_obs);
      end
    end
    checks++;
    if (ifm.valid_o !== 1'b1 || ifm.word_cnt_o !== 16'd1 || ifm.frame_err_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_word: got v=%b cnt=%h err=%b required 1 0001 0",
                         ifm.valid_o, ifm.word_cnt_o, ifm.frame_err_o);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_err_set_wins();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, NCH'($urandom), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (ifm.frame_err_o !== 1'b1 || obs !== exp_obs) begin
      errors++; $display("FAIL err_set_wins: got err=%b (%h) required 1 (%h)", ifm.frame_err_o, obs, exp_obs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(15) != 0), NCH'($urandom),
            ($urandom_range(15) == 0));
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL random cyc%0d: got %h required %h", i, obs, exp_obs);
      end
    end
  endtask

  task automatic test_wrap();
    logic last_bit;
    last_bit = 0;
    cycle(1'b1, 1'b0, '0, 1'b0);
    rst = 1'b0;
    ifw.valid_i = 1'b1;
    for (int n = 1; n <= 65536; n++) begin
      last_bit = 1'($urandom);
      ifw.bit_i = last_bit;
      @(posedge clk);
      #1;
      if (n == 65535) begin
        checks++;
        if (ifw.word_cnt_o !== 16'hFFFF || ifw.valid_o !== 1'b1 || ifw.data_o !== last_bit) begin
          errors++; $display("FAIL wrap_preload: got cnt=%h v=%b d=%b required ffff 1 %b",
                             ifw.word_cnt_o, ifw.valid_o, ifw.data_o, last_bit);
        end
      end
    end
    checks++;
    if (ifw.word_cnt_o !== 16'h0000 || ifw.valid_o !== 1'b1) begin
      errors++; $display("FAIL wrap: got cnt=%h v=%b required 0000 1", ifw.word_cnt_o, ifw.valid_o);
    end
    ifw.valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ifm.valid_i = 1'b0; ifm.bit_i = '0; ifm.err_clr = 1'b0;
    ifw.valid_i = 1'b0; ifw.bit_i = '0; ifw.err_clr = 1'b0;
    nbits = 0; m_valid = 0; m_err = 0; m_busy = 0; m_dm = '0; m_dl = '0; m_cnt = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_short_frame();
    test_lsb_first();
    test_rst_mid();
    test_err_set_wins();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_serial_deser.md
ADC_SERIAL_DESER -- requirements
Module: adc_serial_deser

Interface
REQ-001 Parameter NCH, default 3, number of serial ADC channels deserialized in lockstep.
REQ-002 Parameter WORD_W, default 16, bits per ADC conversion word.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first sampled bit is the word MSB, 0 = first sampled bit is the LSB.
REQ-004 clk  input  1  ADC bit clock; all logic is single-clock and rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  frame gate; high while serial bits are valid.
REQ-007 bit_i  input  NCH  one serial data bit per channel; bit c belongs to channel c.
REQ-008 err_clr  input  1  single-cycle pulse that clears the sticky frame_err_o.
REQ-009 valid_o  output  1  one-cycle strobe marking a complete word on data_o.
REQ-010 data_o  output  NCH*WORD_W  parallel words; channel c occupies bits [WORD_W*(c+1)-1 : WORD_W*c].
REQ-011 word_cnt_o  output  16  count of words emitted since reset.
REQ-012 frame_err_o  output  1  sticky short-frame error flag.
REQ-013 busy_o  output  1  high while a word is partially assembled.

Function
REQ-014 FSM states: IDLE (no partial word) and SHIFT (0 < bits held < WORD_W).
REQ-015 Each cycle valid_i=1, every channel shifts in its bit_i; the bit counter increments by 1.
REQ-016 IDLE -> SHIFT on the first cycle valid_i=1; SHIFT stays in SHIFT while bits held < WORD_W.
REQ-017 When the WORD_W-th bit is sampled, the shift registers transfer to data_o and valid_o=1 on the next cycle (latency 1 cycle from the last bit); the bit counter returns to 0.
REQ-018 Back-to-back: if valid_i stays high past the WORD_W-th bit, the next cycle's bit is bit 0 of the following word; no gap cycle is required or inserted.
REQ-019 MSB_FIRST=1: word = bits in arrival order, first bit at position WORD_W-1; MSB_FIRST=0: first bit at position 0.
REQ-020 data_o holds its value between strobes; valid_o is never high for two consecutive cycles unless WORD_W=1.
REQ-021 Short frame: valid_i falls with 0 < bits held < WORD_W -> partial word discarded, no valid_o, counter cleared, frame_err_o set, FSM -> IDLE.
REQ-022 frame_err_o stays set until err_clr; err_clr and a new short frame in the same cycle -> frame_err_o remains 1 (set wins).
REQ-023 word_cnt_o increments by 1 in the cycle valid_o=1; wraps 0xFFFF -> 0x0000 without a flag.
REQ-024 busy_o = 1 exactly when the FSM is in SHIFT.
REQ-025 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-026 While rst=1: valid_o=0, data_o=0, word_cnt_o=0, frame_err_o=0, busy_o=0, bit counter=0, shift registers=0, FSM=IDLE.
REQ-027 rst asserted mid-word discards the partial word without setting frame_err_o; rst has priority over valid_i and err_clr.
REQ-028 The first cycle after rst deasserts with valid_i=1 samples bit 0 of a new word.

Verification
REQ-029 NCH=3, MSB_FIRST=1, valid_i high 16 cycles; ch0 shifts 0xA5C3, ch1 0x1234, ch2 0xFFFF -> one cycle later valid_o=1, data_o=0xFFFF_1234_A5C3, word_cnt_o=1.
REQ-030 valid_i high 48 cycles continuously, three distinct words per channel -> three valid_o strobes exactly 16 cycles apart, word_cnt_o=3, data correct each strobe.
REQ-031 valid_i high 9 cycles then low -> no valid_o, frame_err_o=1, busy_o=0; next full 16-bit frame emits correctly; err_clr pulse -> frame_err_o=0.
REQ-032 MSB_FIRST=0, ch0 serial sequence 1,0,0,...,0 -> data_o[15:0]=0x0001.
REQ-033 rst asserted after 10 bits -> all outputs 0, frame_err_o=0; following 16-bit frame emits correct word with word_cnt_o=1.
REQ-034 Preload 65535 words then emit one more -> word_cnt_o=0x0000; err_clr coincident with short frame -> frame_err_o=1.
